queue_reader: RTL and testbench
===============================

QUEUE_READER -- requirements
Module: queue_reader

Interface
Parameters:
REQ-001 HOLD_CYCLES, default 10000, number of clock_10KHZ cycles each dequeued byte SHALL be held on data_out (1 s).
REQ-002 TIMEOUT_CYCLES, default 8, number of cycles SHALL wait for the queue's acknowledge before aborting a read.
Ports:
REQ-003 clock_10KHZ  input  1  block clock, rising-edge; reset  input  1  reset, asynchronous, active-high.
REQ-004 enable_in  input  1  level; 1 permits new reads, 0 inhibits new requests (an in-flight read completes).
REQ-005 len_in  input  4  current queue occupancy from the queue block (0..8).
REQ-006 data_in  input  8  queue's registered head-of-line output byte.
REQ-007 dequeue_out  output  1  one-cycle dequeue request pulse to the queue.
REQ-008 data_out  output  8  last byte read, held stable between reads.
REQ-009 data_valid_out  output  1  high while data_out holds a byte inside its hold window.
REQ-010 busy_out  output  1  high in every state except IDLE.
REQ-011 read_count_out  output  8  count of completed reads, wraps 255->0.
REQ-012 timeout_err_out  output  1  sticky; set on any acknowledge timeout, cleared only by reset.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT_ACK, HOLD, GAP; all registers in one clock domain.
REQ-014 IDLE: if enable_in=1 and len_in!=0 -> REQ; else stay.
REQ-015 REQ (exactly 1 cycle): dequeue_out=1, len_snap<=len_in, timer cleared -> WAIT_ACK.
REQ-016 dequeue_out SHALL be 1 only in REQ; never two requests without an intervening WAIT_ACK.
REQ-017 WAIT_ACK: acknowledge = len_in != len_snap; on acknowledge, data_out<=data_in, data_valid_out<=1, read_count_out+1, hold counter cleared -> HOLD.
REQ-018 WAIT_ACK: timer increments each cycle without acknowledge; on timer==TIMEOUT_CYCLES-1 -> timeout_err_out<=1, data_out/data_valid_out unchanged, read_count_out unchanged -> GAP.
REQ-019 Acknowledge and timeout in the same cycle: acknowledge wins.
REQ-020 Nominal latency: REQ at edge N, queue updates len/data at edge N+2, capture at edge N+3; read_count_out visible after edge N+3.
REQ-021 HOLD: counter increments; at HOLD_CYCLES-1 -> data_valid_out<=0 -> GAP; data_out keeps its value after the window.
REQ-022 GAP: exactly 1 cycle -> IDLE; guarantees queue FSM has returned to its idle state before the next request.
REQ-023 enable_in deasserted in REQ/WAIT_ACK/HOLD SHALL not abort the sequence; only IDLE checks enable_in.
REQ-024 len_in rising (concurrent enqueue) during WAIT_ACK counts as acknowledge only if it differs from len_snap; spec accepts this and the captured byte is the queue's data_in at that cycle.
REQ-025 Counters SHALL be sized to hold HOLD_CYCLES-1 and TIMEOUT_CYCLES-1 without overflow; read_count_out wraps modulo 256 with no flag.
REQ-026 len_in>8 SHALL be treated as nonzero (no range check).

Reset
REQ-027 reset=1 SHALL immediately force: state IDLE, dequeue_out=0, data_out=0x00, data_valid_out=0, busy_out=0, read_count_out=0, timeout_err_out=0, len_snap/timers=0.
REQ-028 reset mid-read (any state) SHALL abandon the read with no pulse emitted after reset release; first request no earlier than the 2nd edge after release.

Verification
REQ-029 Single read: HOLD_CYCLES=4, queue model holds 0xA5, len 1, enable 1 -> one dequeue pulse, data_out=0xA5 with data_valid_out high 4 cycles, read_count_out=1, then idle with len 0.
REQ-030 Drain: queue loaded 0x11,0x22,0x33 -> three pulses spaced >= HOLD_CYCLES+4 cycles, data_out sequence 0x11,0x22,0x33, read_count_out=3, no further pulse.
REQ-031 Timeout: TIMEOUT_CYCLES=8, len_in held at 2 never changing -> one pulse, timeout_err_out=1 after 8 WAIT_ACK cycles, data_valid_out stays 0, read_count_out=0, retry after GAP.
REQ-032 Enable gating: len_in=3, enable_in=0 -> dequeue_out stays 0; drop enable_in during HOLD -> current hold completes, no new request.
REQ-033 Reset mid-HOLD: assert reset with data_out=0x5A valid -> all outputs 0 same cycle, no pulse during reset, normal read resumes after release.
REQ-034 Wrap: 256 completed reads -> read_count_out returns to 0x00, timeout_err_out remains 0.

Source files
------------

// File: rtl/queue_reader.sv
// Reads one byte at a time from the queue block and holds each byte on data_out for HOLD_CYCLES.
// The queue's acknowledge is taken from a change in its occupancy.
module queue_reader #(
  parameter int HOLD_CYCLES    = 10000,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic       clock_10KHZ,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [3:0] len_in,
  input  logic [7:0] data_in,
  output logic       dequeue_out,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  output logic       busy_out,
  output logic [7:0] read_count_out,
  output logic       timeout_err_out
);

  localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t               state, next_state;
  logic                 armed, next_armed;
  logic [3:0]           len_snap, next_len_snap;
  logic [TIMEOUT_W-1:0] timer, next_timer;
  logic [HOLD_W-1:0]    hold_cnt, next_hold_cnt;
  logic [7:0]           next_data;
  logic                 next_valid;
  logic [7:0]           next_count;
  logic                 next_err;

  // Next-state and next-register values; every register keeps its value unless a state moves it.
  always_comb begin
    next_state    = state;
    next_armed    = 1'b1;
    next_len_snap = len_snap;
    next_timer    = timer;
    next_hold_cnt = hold_cnt;
    next_data     = data_out;
    next_valid    = data_valid_out;
    next_count    = read_count_out;
    next_err      = timeout_err_out;
    case (state)
      IDLE: begin
        // armed stays low for the first edge after reset so no request follows release immediately
        if (armed && enable_in && (len_in != 4'd0)) begin
          next_state = REQ;
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        next_len_snap = len_in;
        next_timer    = '0;
        next_state    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (len_in != len_snap) begin
          next_data     = data_in;
          next_valid    = 1'b1;
          next_count    = read_count_out + 8'd1;
          next_hold_cnt = '0;
          next_state    = HOLD;
        end else if (timer == TIMEOUT_LAST) begin
          next_err   = 1'b1;
          next_state = GAP;
        end else begin
          next_timer = timer + TIMEOUT_W'(1);
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          next_valid = 1'b0;
          next_state = GAP;
        end else begin
          next_hold_cnt = hold_cnt + HOLD_W'(1);
        end
      end
      GAP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; dequeue/busy are decoded from the next state.
  always_ff @(posedge clock_10KHZ or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      armed           <= 1'b0;
      len_snap        <= 4'd0;
      timer           <= '0;
      hold_cnt        <= '0;
      dequeue_out     <= 1'b0;
      data_out        <= 8'h00;
      data_valid_out  <= 1'b0;
      busy_out        <= 1'b0;
      read_count_out  <= 8'd0;
      timeout_err_out <= 1'b0;
    end else begin
      state           <= next_state;
      armed           <= next_armed;
      len_snap        <= next_len_snap;
      timer           <= next_timer;
      hold_cnt        <= next_hold_cnt;
      dequeue_out     <= (next_state == REQ);
      data_out        <= next_data;
      data_valid_out  <= next_valid;
      busy_out        <= (next_state != IDLE);
      read_count_out  <= next_count;
      timeout_err_out <= next_err;
    end
  end

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader with a small queue model that pops one edge after seeing a request.
module tb_queue_reader;

  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic       clock_10KHZ = 1'b0;
  logic       reset       = 1'b1;
  logic       enable_in   = 1'b0;
  logic [3:0] len_in;
  logic [7:0] data_in     = 8'h00;
  logic       dequeue_out;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       busy_out;
  logic [7:0] read_count_out;
  logic       timeout_err_out;

  // queue model: stimulus writes mem/wp, the model alone advances rp
  logic [7:0] mem [0:255];
  logic [7:0] wp       = 8'd0;
  logic [7:0] rp       = 8'd0;
  logic       deq_d    = 1'b0;
  logic       model_on = 1'b1;
  logic [3:0] man_len  = 4'd0;

  assign len_in = model_on ? 4'(wp - rp) : man_len;

  always #5 clock_10KHZ = ~clock_10KHZ;

  queue_reader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_10KHZ    (clock_10KHZ),
    .reset          (reset),
    .enable_in      (enable_in),
    .len_in         (len_in),
    .data_in        (data_in),
    .dequeue_out    (dequeue_out),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .busy_out       (busy_out),
    .read_count_out (read_count_out),
    .timeout_err_out(timeout_err_out)
  );

  always @(posedge clock_10KHZ) begin
    deq_d <= dequeue_out;
    if (model_on && deq_d && (wp != rp)) begin
      data_in <= mem[rp];
      rp      <= rp + 8'd1;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 8'd1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!data_valid_out && k < 20) begin
      @(negedge clock_10KHZ);
      k++;
    end
    check(name, int'(k < 20), 1);
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       en;
    int         pulses;
    int         valid_cyc;
    logic [7:0] exp_data;
    int         exp_count;
    int         exp_len;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int p, v, np, nd, k, slow;
    int pulse_t [4];
    logic [7:0] got [4];
    logic prev_valid;

    vecs[0] = '{8'hA5, 1'b1, 1, 4, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b1, 1, 4, 8'h3C, 2, 0};
    vecs[2] = '{8'hFF, 1'b0, 0, 0, 8'h3C, 2, 1};
    vecs[3] = '{8'h00, 1'b1, 1, 4, 8'h00, 3, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 4, 8'h80, 4, 0};

    // reset state
    repeat (3) @(negedge clock_10KHZ);
    check("rst_deq",   int'(dequeue_out), 0);
    check("rst_data",  int'(data_out), 0);
    check("rst_valid", int'(data_valid_out), 0);
    check("rst_busy",  int'(busy_out), 0);
    check("rst_count", int'(read_count_out), 0);
    check("rst_err",   int'(timeout_err_out), 0);
    reset = 1'b0;

    // table of single reads
    for (int i = 0; i < 5; i++) begin
      enable_in = vecs[i].en;
      push(vecs[i].byte_v);
      p = 0;
      v = 0;
      repeat (20) begin
        @(negedge clock_10KHZ);
        p += int'(dequeue_out);
        v += int'(data_valid_out);
      end
      check($sformatf("vec%0d_pulses", i), p, vecs[i].pulses);
      check($sformatf("vec%0d_valid_cyc", i), v, vecs[i].valid_cyc);
      check($sformatf("vec%0d_data", i), int'(data_out), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_count", i), int'(read_count_out), vecs[i].exp_count);
      check($sformatf("vec%0d_len", i), int'(len_in), vecs[i].exp_len);
      check($sformatf("vec%0d_busy", i), int'(busy_out), 0);
      check($sformatf("vec%0d_err", i), int'(timeout_err_out), 0);
      wp = rp;
    end

    // drain three bytes
    enable_in = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    np = 0; nd = 0; prev_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock_10KHZ);
      if (dequeue_out && np < 4) begin pulse_t[np] = c; np++; end
      if (data_valid_out && !prev_valid && nd < 4) begin got[nd] = data_out; nd++; end
      prev_valid = data_valid_out;
    end
    check("drain_pulses", np, 3);
    check("drain_reads", nd, 3);
    check("drain_d0", int'(got[0]), 'h11);
    check("drain_d1", int'(got[1]), 'h22);
    check("drain_d2", int'(got[2]), 'h33);
    check("drain_gap01", int'((pulse_t[1] - pulse_t[0]) >= HOLD + 4), 1);
    check("drain_gap12", int'((pulse_t[2] - pulse_t[1]) >= HOLD + 4), 1);
    check("drain_count", int'(read_count_out), 7);
    check("drain_len", int'(len_in), 0);

    // enable gating
    enable_in = 1'b0;
    push(8'h41); push(8'h42); push(8'h43);
    p = 0;
    repeat (10) begin @(negedge clock_10KHZ); p += int'(dequeue_out); end
    check("gate_no_req", p, 0);
    enable_in = 1'b1;
    wait_valid("gate_wait_valid");
    enable_in = 1'b0;
    v = 1; p = 0;
    repeat (30) begin
      @(negedge clock_10KHZ);
      v += int'(data_valid_out);
      p += int'(dequeue_out);
    end
    check("gate_hold_cyc", v, HOLD);
    check("gate_data", int'(data_out), 'h41);
    check("gate_extra_req", p, 0);
    check("gate_count", int'(read_count_out), 8);
    check("gate_len", int'(len_in), 2);
    wp = rp;
    enable_in = 1'b1;

    // 248 more reads wrap the counter to zero
    slow = 0;
    for (int b = 0; b < 31; b++) begin
      for (int j = 0; j < 8; j++) push(8'(b * 8 + j));
      k = 0;
      do begin @(negedge clock_10KHZ); k++; end while ((wp != rp || busy_out) && k < 200);
      if (k >= 200) slow++;
      if (b == 29) check("wrap_count_248", int'(read_count_out), 248);
    end
    check("wrap_bounded", slow, 0);
    check("wrap_count", int'(read_count_out), 0);
    check("wrap_err", int'(timeout_err_out), 0);

    // acknowledge timeout: len never changes
    model_on = 1'b0;
    man_len  = 4'd2;
    k = 0;
    while (!dequeue_out && k < 10) begin @(negedge clock_10KHZ); k++; end
    check("tmo_first_req", int'(k < 10), 1);
    repeat (TMO) @(negedge clock_10KHZ);
    check("tmo_err_early", int'(timeout_err_out), 0);
    check("tmo_busy", int'(busy_out), 1);
    @(negedge clock_10KHZ);
    check("tmo_err", int'(timeout_err_out), 1);
    check("tmo_valid", int'(data_valid_out), 0);
    check("tmo_count", int'(read_count_out), 0);
    k = 0;
    do begin @(negedge clock_10KHZ); k++; end while (!dequeue_out && k < 6);
    check("tmo_retry", k, 2);
    enable_in = 1'b0;
    k = 0;
    while (busy_out && k < 30) begin @(negedge clock_10KHZ); k++; end
    check("tmo_idle", int'(k < 30), 1);
    man_len   = 4'd0;
    model_on  = 1'b1;
    enable_in = 1'b1;

    // reset during HOLD
    push(8'h5A);
    wait_valid("rsth_wait_valid");
    check("rsth_data", int'(data_out), 'h5A);
    #2;
    reset = 1'b1;
    #1;
    check("rsth_deq",   int'(dequeue_out), 0);
    check("rsth_data0", int'(data_out), 0);
    check("rsth_valid", int'(data_valid_out), 0);
    check("rsth_busy",  int'(busy_out), 0);
    check("rsth_count", int'(read_count_out), 0);
    check("rsth_err",   int'(timeout_err_out), 0);
    push(8'h77);
    p = 0;
    repeat (3) begin @(negedge clock_10KHZ); p += int'(dequeue_out); end
    check("rsth_no_pulse", p, 0);
    reset = 1'b0;
    @(negedge clock_10KHZ);
    check("rsth_edge1", int'(dequeue_out), 0);
    @(negedge clock_10KHZ);
    check("rsth_edge2", int'(dequeue_out), 1);
    wait_valid("rsth_resume_valid");
    check("rsth_resume_data", int'(data_out), 'h77);
    check("rsth_resume_count", int'(read_count_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
